// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - round-robin controller time-sharing one external adder among requesters
// Optional ADDER_CARRY_CHAIN_EN: lock a requester across multi-word carry chains.
`ifndef ADDER_SIZE
`define ADDER_SIZE 32
`endif

module adder_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = `ADDER_SIZE,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_op1,
    input  logic [NUM_REQ*DATA_W-1:0]   req_op2,
    input  logic [NUM_REQ-1:0]          req_cin,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [DATA_W-1:0]           add_op1,
    output logic [DATA_W-1:0]           add_op2,
    output logic                        add_cin,
    input  logic [DATA_W-1:0]           add_res,
    input  logic                        add_cout,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [DATA_W-1:0]           rsp_sum,
    output logic                        rsp_cout
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    logic                r_cin;
    logic [DATA_W-1:0]   r_sum;
    logic                r_cout;

    logic [DATA_W-1:0]   w_op1_arr [NUM_REQ];
    logic [DATA_W-1:0]   w_op2_arr [NUM_REQ];
    logic                w_rr_found;
    logic [ID_W-1:0]     w_rr_gnt;
    logic [ID_W-1:0]     w_idx;
    logic                w_found;
    logic [ID_W-1:0]     w_gnt;
    logic [ID_W-1:0]     w_gnt_inc;
    logic                w_accept;
    logic                w_cin_sel;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_op1_arr[i] = req_op1[i*DATA_W +: DATA_W];
        assign w_op2_arr[i] = req_op2[i*DATA_W +: DATA_W];
    end

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_gnt   = '0;
        w_idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_rr_found && req_valid[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_gnt   = w_idx;
            end
        end
    end

`ifdef ADDER_CARRY_CHAIN_EN
    logic            r_lock;
    logic [ID_W-1:0] r_lock_id;

    assign w_found   = r_lock ? req_valid[r_lock_id] : w_rr_found;
    assign w_gnt     = r_lock ? r_lock_id : w_rr_gnt;
    assign w_cin_sel = r_lock ? r_cout : req_cin[w_gnt];
`else
    logic w_unused_last;

    assign w_unused_last = ^req_last;
    assign w_found       = w_rr_found;
    assign w_gnt         = w_rr_gnt;
    assign w_cin_sel     = req_cin[w_gnt];
`endif

    assign w_accept  = (r_state == S_IDLE) && w_found;
    assign w_gnt_inc = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        req_ready = '0;
        req_ready[w_gnt] = w_accept & ~rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_cin    <= 1'b0;
            r_id     <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_rr_ptr <= '0;
`ifdef ADDER_CARRY_CHAIN_EN
            r_lock    <= 1'b0;
            r_lock_id <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_op1 <= w_op1_arr[w_gnt];
                r_op2 <= w_op2_arr[w_gnt];
                r_cin <= w_cin_sel;
                r_id  <= w_gnt;
`ifdef ADDER_CARRY_CHAIN_EN
                // Pointer only moves once the whole chain has been accepted.
                if (req_last[w_gnt]) begin
                    r_lock   <= 1'b0;
                    r_rr_ptr <= w_gnt_inc;
                end else begin
                    r_lock    <= 1'b1;
                    r_lock_id <= w_gnt;
                end
`else
                r_rr_ptr <= w_gnt_inc;
`endif
            end
            if (r_state == S_EXEC) begin
                r_sum  <= add_res;
                r_cout <= add_cout;
            end
        end
    end

    assign add_op1   = r_op1;
    assign add_op2   = r_op2;
    assign add_cin   = r_cin;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;

endmodule
